// File: rtl/inst_fetch_queue_if.sv
// Fetch-to-decode handshake bundle for the instruction fetch queue.
// The master side is the fetch/decode environment; the slave side is the queue.
interface inst_fetch_queue_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int CNT_W  = 3
);
    logic              rdy;
    logic              flush;
    logic              in_valid;
    logic [ADDR_W-1:0] in_pc;
    logic [INST_W-1:0] in_inst;
    logic              in_ready;
    logic              out_valid;
    logic [ADDR_W-1:0] out_pc;
    logic [INST_W-1:0] out_inst;
    logic              out_ready;
    logic [CNT_W-1:0]  count;

    modport master (
        output rdy, flush, in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, count
    );

    modport slave (
        input  rdy, flush, in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_inst, count
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: circular buffer of {pc, inst} entries between
// fetch and decode. No bypass path, so an entry pushed into an empty queue
// appears at the output one cycle later. rdy=0 freezes all state; flush
// empties the queue; rst has priority over everything.
module inst_fetch_queue #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    inst_fetch_queue_if.slave    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  cnt;
    logic              push;
    logic              pop;

    // Handshake qualifiers and head read-out; flush and rst gate both sides
    // so a same-cycle push/pop never happens alongside a flush or reset.
    always_comb begin
        bus.in_ready  = bus.rdy & ~rst & ~bus.flush & (cnt != CNT_FULL);
        bus.out_valid = bus.rdy & ~rst & ~bus.flush & (cnt != '0);
        push          = bus.in_valid & bus.in_ready;
        pop           = bus.out_valid & bus.out_ready;
        bus.out_pc    = pc_mem[head];
        bus.out_inst  = bus.out_valid ? inst_mem[head] : '0;
        bus.count     = cnt;
    end

    // Entry storage; not reset, since stale slots are never presented as valid.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail]   <= bus.in_pc;
            inst_mem[tail] <= bus.in_inst;
        end
    end

    // Pointer and occupancy update: rst > freeze > flush > push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (bus.rdy) begin
            if (bus.flush) begin
                head <= '0;
                tail <= '0;
                cnt  <= '0;
            end else begin
                if (push) tail <= tail + PTR_W'(1);
                if (pop)  head <= head + PTR_W'(1);
                case ({push, pop})
                    2'b10:   cnt <= cnt + CNT_W'(1);
                    2'b01:   cnt <= cnt - CNT_W'(1);
                    default: cnt <= cnt;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue (DEPTH=4): a vector table covering
// reset, fill/drain, full-with-pop, flush, rdy freeze and mid-stream reset,
// plus a hand-written sustained push+pop wrap-around sequence.
module tb_inst_fetch_queue;
    localparam int ADDR_W = 32;
    localparam int INST_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 3;

    typedef struct {
        logic              rst;
        logic              rdy;
        logic              flush;
        logic              in_valid;
        logic [ADDR_W-1:0] in_pc;
        logic              out_ready;
        logic              e_in_ready;
        logic              e_out_valid;
        logic [ADDR_W-1:0] e_pc;
        logic              chk_pc;
        logic [CNT_W-1:0]  e_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[$];

    inst_fetch_queue_if #(.ADDR_W(ADDR_W), .INST_W(INST_W), .CNT_W(CNT_W)) bus ();

    inst_fetch_queue #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [INST_W-1:0] inst_of(input logic [ADDR_W-1:0] pc);
        return pc ^ 32'hDEAD_0000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic rd, input logic fl, input logic iv,
                       input logic [ADDR_W-1:0] pc, input logic ordy,
                       input logic eir, input logic eov, input logic [ADDR_W-1:0] epc,
                       input logic cpc, input logic [CNT_W-1:0] ecnt);
        vec_t v;
        v.rst = r; v.rdy = rd; v.flush = fl; v.in_valid = iv; v.in_pc = pc;
        v.out_ready = ordy; v.e_in_ready = eir; v.e_out_valid = eov;
        v.e_pc = epc; v.chk_pc = cpc; v.e_cnt = ecnt;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic rd, input logic fl, input logic iv,
                         input logic [ADDR_W-1:0] pc, input logic ordy);
        rst           = r;
        bus.rdy       = rd;
        bus.flush     = fl;
        bus.in_valid  = iv;
        bus.in_pc     = pc;
        bus.in_inst   = inst_of(pc);
        bus.out_ready = ordy;
    endtask

    initial begin
        logic [ADDR_W-1:0] q[$];
        logic [ADDR_W-1:0] next_pc;

        // rst rdy fl iv  pc      ordy | in_rdy out_v  pc     chk cnt
        add(1, 1, 0, 1, 32'h100, 1,     0, 0, 32'h0,  0, 0);
        // fill
        add(0, 1, 0, 1, 32'h0,   0,     1, 0, 32'h0,  0, 0);
        add(0, 1, 0, 1, 32'h4,   0,     1, 1, 32'h0,  1, 1);
        add(0, 1, 0, 1, 32'h8,   0,     1, 1, 32'h0,  1, 2);
        add(0, 1, 0, 1, 32'hC,   0,     1, 1, 32'h0,  1, 3);
        add(0, 1, 0, 1, 32'h10,  0,     0, 1, 32'h0,  1, 4);
        // full with pop: push blocked, then accepted next cycle
        add(0, 1, 0, 1, 32'h10,  1,     0, 1, 32'h0,  1, 4);
        add(0, 1, 0, 1, 32'h10,  0,     1, 1, 32'h4,  1, 3);
        // drain
        add(0, 1, 0, 0, 32'h0,   1,     0, 1, 32'h4,  1, 4);
        add(0, 1, 0, 0, 32'h0,   1,     1, 1, 32'h8,  1, 3);
        add(0, 1, 0, 0, 32'h0,   1,     1, 1, 32'hC,  1, 2);
        add(0, 1, 0, 0, 32'h0,   1,     1, 1, 32'h10, 1, 1);
        add(0, 1, 0, 0, 32'h0,   1,     1, 0, 32'h0,  0, 0);
        // flush at count=3 with push pending
        add(0, 1, 0, 1, 32'h20,  0,     1, 0, 32'h0,  0, 0);
        add(0, 1, 0, 1, 32'h24,  0,     1, 1, 32'h20, 1, 1);
        add(0, 1, 0, 1, 32'h28,  0,     1, 1, 32'h20, 1, 2);
        add(0, 1, 1, 1, 32'h2C,  1,     0, 0, 32'h0,  0, 3);
        add(0, 1, 0, 1, 32'h30,  0,     1, 0, 32'h0,  0, 0);
        add(0, 1, 0, 0, 32'h0,   0,     1, 1, 32'h30, 1, 1);
        // rdy freeze at count=2, all other controls active
        add(0, 1, 0, 1, 32'h34,  0,     1, 1, 32'h30, 1, 1);
        add(0, 0, 1, 1, 32'h38,  1,     0, 0, 32'h0,  0, 2);
        add(0, 0, 1, 1, 32'h38,  1,     0, 0, 32'h0,  0, 2);
        add(0, 0, 1, 1, 32'h38,  1,     0, 0, 32'h0,  0, 2);
        add(0, 1, 0, 0, 32'h0,   0,     1, 1, 32'h30, 1, 2);
        // reset mid-stream at count=3
        add(0, 1, 0, 1, 32'h38,  0,     1, 1, 32'h30, 1, 2);
        add(1, 1, 0, 1, 32'h3C,  1,     0, 0, 32'h0,  0, 3);
        add(0, 1, 0, 1, 32'h40,  0,     1, 0, 32'h0,  0, 0);
        add(0, 1, 0, 0, 32'h0,   1,     1, 1, 32'h40, 1, 1);
        add(0, 1, 0, 0, 32'h0,   0,     1, 0, 32'h0,  0, 0);

        // pre-table reset so registers are defined
        drive(1, 1, 0, 0, 32'h0, 0);
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            #1;
            drive(vecs[i].rst, vecs[i].rdy, vecs[i].flush, vecs[i].in_valid,
                  vecs[i].in_pc, vecs[i].out_ready);
            @(negedge clk);
            check($sformatf("v%0d in_ready", i), 64'(bus.in_ready), 64'(vecs[i].e_in_ready));
            check($sformatf("v%0d out_valid", i), 64'(bus.out_valid), 64'(vecs[i].e_out_valid));
            check($sformatf("v%0d count", i), 64'(bus.count), 64'(vecs[i].e_cnt));
            if (vecs[i].chk_pc) begin
                check($sformatf("v%0d out_pc", i), 64'(bus.out_pc), 64'(vecs[i].e_pc));
                check($sformatf("v%0d out_inst", i), 64'(bus.out_inst), 64'(inst_of(vecs[i].e_pc)));
            end else begin
                check($sformatf("v%0d out_inst bubble", i), 64'(bus.out_inst), 64'h0);
            end
            @(posedge clk);
        end

        // wrap-around: prime count=2, then 10 cycles of push+pop
        next_pc = 32'h1000;
        for (int k = 0; k < 2; k++) begin
            #1;
            drive(0, 1, 0, 1, next_pc, 0);
            q.push_back(next_pc);
            next_pc += 4;
            @(posedge clk);
        end
        for (int k = 0; k < 10; k++) begin
            #1;
            drive(0, 1, 0, 1, next_pc, 1);
            @(negedge clk);
            check($sformatf("wrap%0d count", k), 64'(bus.count), 64'd2);
            check($sformatf("wrap%0d in_ready", k), 64'(bus.in_ready), 64'd1);
            check($sformatf("wrap%0d out_pc", k), 64'(bus.out_pc), 64'(q[0]));
            check($sformatf("wrap%0d out_inst", k), 64'(bus.out_inst), 64'(inst_of(q[0])));
            q.push_back(next_pc);
            void'(q.pop_front());
            next_pc += 4;
            @(posedge clk);
        end
        for (int k = 0; k < 2; k++) begin
            #1;
            drive(0, 1, 0, 0, 32'h0, 1);
            @(negedge clk);
            check($sformatf("wrapdrain%0d out_pc", k), 64'(bus.out_pc), 64'(q[0]));
            check($sformatf("wrapdrain%0d count", k), 64'(bus.count), 64'(2 - k));
            void'(q.pop_front());
            @(posedge clk);
        end
        #1;
        drive(0, 1, 0, 0, 32'h0, 0);
        @(negedge clk);
        check("wrap final count", 64'(bus.count), 64'd0);
        check("wrap final out_valid", 64'(bus.out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
